// File: rtl/clz_normalizer.sv
// Iterative count-leading-zeros/ones with normalised result.
// Five-step binary search, one step per clock, start/busy/done handshake.
module clz_normalizer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ones,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic [5:0]  count,
  output logic [31:0] norm,
  output logic        zero
);

  typedef enum logic {IDLE, SEARCH} state_e;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] key_q, key_d;
  logic [31:0] shadow_q, shadow_d;
  logic [4:0]  acc_q, acc_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] norm_q, norm_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;

  logic [4:0]  s;
  logic        hit;
  logic [31:0] key_s;
  logic [31:0] shadow_s;
  logic [4:0]  acc_s;

  // One search step: shift by s when the top s bits of key are clear
  always_comb begin
    s   = 5'd1;
    hit = 1'b0;
    unique case (step_q)
      3'd0: begin s = 5'd16; hit = (key_q[31:16] == '0); end
      3'd1: begin s = 5'd8;  hit = (key_q[31:24] == '0); end
      3'd2: begin s = 5'd4;  hit = (key_q[31:28] == '0); end
      3'd3: begin s = 5'd2;  hit = (key_q[31:30] == '0); end
      default: begin s = 5'd1; hit = ~key_q[31]; end
    endcase
    key_s    = hit ? (key_q << s) : key_q;
    shadow_s = hit ? (shadow_q << s) : shadow_q;
    acc_s    = hit ? (acc_q + s) : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    key_d    = key_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    count_d  = count_q;
    norm_d   = norm_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEARCH;
          key_d    = ones ? ~data : data;
          shadow_d = data;
          step_d   = 3'd0;
          acc_d    = 5'd0;
        end
      end
      SEARCH: begin
        key_d    = key_s;
        shadow_d = shadow_s;
        acc_d    = acc_s;
        step_d   = step_q + 3'd1;
        if (step_q == 3'd4) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (key_s[31]) begin
            count_d = {1'b0, acc_s};
            norm_d  = shadow_s;
            zero_d  = 1'b0;
          end else begin
            count_d = 6'd32;
            norm_d  = '0;
            zero_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      key_q    <= '0;
      shadow_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      norm_q   <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      key_q    <= key_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      norm_q   <= norm_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q == SEARCH);
  assign done  = done_q;
  assign count = count_q;
  assign norm  = norm_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_clz_normalizer.sv
// Directed bench for clz_normalizer.
// Vectors carry hand-computed counts and normalised words.
module tb_clz_normalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ones;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic [31:0] norm;
  logic        zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clz_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ones  (ones),
    .data  (data),
    .busy  (busy),
    .done  (done),
    .count (count),
    .norm  (norm),
    .zero  (zero)
  );

  // Launch one op; lat = edges from load edge to done (-1 on timeout)
  task automatic do_op(input logic o, input logic [31:0] d,
                       output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    @(negedge clk);
    start = 1'b1; ones = o; data = d;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) bcnt++;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ones = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, count, norm, zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b count=%0d norm=%h zero=%b, want all 0",
               busy, done, count, norm, zero);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_clz_basic();
    int lat, bc;
    do_op(1'b0, 32'h0000_8000, lat, bc);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL clz_latency: got %0d edges, want 5", lat);
    end
    checks++;
    if (bc !== 5) begin
      errors++;
      $display("FAIL clz_busy_len: got %0d cycles, want 5", bc);
    end
    checks++;
    if (count !== 6'd16 || norm !== 32'h8000_0000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL clz_8000: got count=%0d norm=%h zero=%b, want 16 80000000 0",
               count, norm, zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || count !== 6'd16) begin
      errors++;
      $display("FAIL done_pulse: got done=%b count=%0d, want 0 16", done, count);
    end
  endtask

  task automatic test_vectors();
    logic        vo [7];
    logic [31:0] vd [7];
    logic [5:0]  vc [7];
    logic [31:0] vn [7];
    logic        vz [7];
    int lat, bc;
    vo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vd = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF,
           32'hFFF1_2345, 32'h7FFF_FFFF, 32'h0012_3400};
    vc = '{6'd0, 6'd31, 6'd32, 6'd32, 6'd12, 6'd0, 6'd11};
    vn = '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0,
           32'h1234_5000, 32'h7FFF_FFFF, 32'h91A0_0000};
    vz = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_op(vo[i], vd[i], lat, bc);
      checks++;
      if (lat !== 5 || count !== vc[i] || norm !== vn[i] || zero !== vz[i]) begin
        errors++;
        $display("FAIL vec%0d: got lat=%0d count=%0d norm=%h zero=%b, want 5 %0d %h %b",
                 i, lat, count, norm, zero, vc[i], vn[i], vz[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    logic [5:0] c = '0;
    @(negedge clk);
    start = 1'b1; ones = 1'b0; data = 32'h0000_00FF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; data = 32'h0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; c = count; end
    end
    checks++;
    if (ndone !== 1 || c !== 6'd24) begin
      errors++;
      $display("FAIL busy_start_ignored: got dones=%0d count=%0d, want 1 24", ndone, c);
    end
  endtask

  task automatic test_reset_abort_and_b2b();
    int ndone = 0;
    int gap = -1;
    @(negedge clk);
    start = 1'b1; ones = 1'b0; data = 32'h0000_0100;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, count, norm, zero} !== '0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b done=%b count=%0d norm=%h zero=%b, want all 0",
               busy, done, count, norm, zero);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d dones, want 0", ndone);
    end
    @(negedge clk);
    start = 1'b1; data = 32'h0001_0000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || count !== 6'd15 || norm !== 32'h8000_0000) begin
      errors++;
      $display("FAIL b2b_first: got done=%b count=%0d norm=%h, want 1 15 80000000",
               done, count, norm);
    end
    start = 1'b1; data = 32'h0000_0004;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || count !== 6'd15) begin
      errors++;
      $display("FAIL b2b_hold: got busy=%b count=%0d, want 1 15", busy, count);
    end
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin gap = i; break; end
    end
    checks++;
    if (gap !== 6 || count !== 6'd29 || norm !== 32'h8000_0000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got gap=%0d count=%0d norm=%h zero=%b, want 6 29 80000000 0",
               gap, count, norm, zero);
    end
  endtask

  initial begin
    test_reset();
    test_clz_basic();
    test_vectors();
    test_start_while_busy();
    test_reset_abort_and_b2b();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
